// File: rtl/spi_flash_reader_pkg.sv
// rtl/spi_flash_reader_pkg.sv - flash opcodes and reader FSM state encoding
package spi_flash_reader_pkg;

  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_RDID = 8'h9F;
  localparam logic [7:0] OP_RDSR = 8'h05;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_GAP
  } state_e;

endpackage

// File: rtl/spi_flash_reader_sck_gen.sv
// rtl/spi_flash_reader_sck_gen.sv - SCK divider with rise/fall strobes and freeze
module spi_flash_reader_sck_gen #(
  parameter int DIV = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic freeze_i,
  output logic sck_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sck_q, sck_d;
  logic             wrap;
  logic             step;

  assign wrap   = (cnt_q == CNT_W'(DIV - 1));
  assign step   = en_i && !freeze_i;
  // Strobes mark the cycle whose closing edge toggles SCK.
  assign rise_o = step && wrap && !sck_q;
  assign fall_o = step && wrap && sck_q;
  assign sck_o  = sck_q;

  always_comb begin
    cnt_d = cnt_q;
    sck_d = sck_q;
    if (!en_i) begin
      cnt_d = '0;
      sck_d = 1'b0;
    end else if (step) begin
      if (wrap) begin
        cnt_d = '0;
        sck_d = !sck_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

endmodule

// File: rtl/spi_flash_reader.sv
// rtl/spi_flash_reader.sv - SPI mode-0 READ initiator streaming flash bytes out
module spi_flash_reader
  import spi_flash_reader_pkg::*;
#(
  parameter int         DIV    = 1,
  parameter logic [7:0] CMD    = OP_READ,
  parameter int         LEN_W  = 16,
  parameter int         CS_GAP = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [23:0]      addr_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [7:0]       out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             flash_csn_o,
  output logic             flash_sck_o,
  output logic             flash_mosi_o,
  input  logic             flash_miso_i,
  output logic             flash_wpn_o,
  output logic             flash_holdn_o
);

  localparam int             GAP_W   = 16;
  localparam logic [GAP_W-1:0] DIV_M1  = GAP_W'(DIV - 1);
  localparam logic [GAP_W-1:0] GAP_END = GAP_W'(DIV + CS_GAP - 1);

  state_e             state_q, state_d;
  logic               csn_q, csn_d;
  logic [31:0]        tx_q, tx_d;
  logic [6:0]         rx_q, rx_d;
  logic [4:0]         bit_cnt_q, bit_cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [7:0]         out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;

  logic sck, rise, fall, sck_run, freeze;

  assign sck_run = (state_q == ST_CMD) || (state_q == ST_ADDR) || (state_q == ST_DATA);
  // Park SCK low just before a byte would complete into an occupied output slot.
  assign freeze  = (state_q == ST_DATA) && (bit_cnt_q == 5'd7) && !sck &&
                   out_valid_q && !out_ready_i;

  spi_flash_reader_sck_gen #(.DIV(DIV)) u_sck_gen (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en_i     (sck_run),
    .freeze_i (freeze),
    .sck_o    (sck),
    .rise_o   (rise),
    .fall_o   (fall)
  );

  always_comb begin
    state_d     = state_q;
    csn_d       = csn_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    bit_cnt_d   = bit_cnt_q;
    len_d       = len_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    gap_cnt_d   = gap_cnt_q;
    if (out_valid_q && out_ready_i) out_valid_d = 1'b0;
    if (fall) tx_d = {tx_q[30:0], 1'b0};
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          busy_d    = 1'b1;
          bit_cnt_d = '0;
          len_d     = len_i;
          if (len_i != '0) begin
            csn_d   = 1'b0;
            tx_d    = {CMD, addr_i};
            state_d = ST_CMD;
          end else begin
            gap_cnt_d = GAP_END;
            state_d   = ST_GAP;
          end
        end
      end
      ST_CMD: begin
        if (rise) begin
          bit_cnt_d = (bit_cnt_q == 5'd7) ? 5'd0 : bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd7) state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (rise) begin
          bit_cnt_d = (bit_cnt_q == 5'd23) ? 5'd0 : bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd23) state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (rise) begin
          rx_d      = {rx_q[5:0], flash_miso_i};
          bit_cnt_d = (bit_cnt_q == 5'd7) ? 5'd0 : bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd7) begin
            out_data_d  = {rx_q, flash_miso_i};
            out_valid_d = 1'b1;
            if (len_q != '0) len_d = len_q - LEN_W'(1);
          end
        end
        if (fall && (len_q == '0)) begin
          gap_cnt_d = '0;
          state_d   = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == DIV_M1) csn_d = 1'b1;
        if (gap_cnt_q != GAP_END) begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end else if (!out_valid_q || out_ready_i) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      csn_q       <= 1'b1;
      tx_q        <= '0;
      rx_q        <= '0;
      bit_cnt_q   <= '0;
      len_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      gap_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      csn_q       <= csn_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      bit_cnt_q   <= bit_cnt_d;
      len_q       <= len_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign out_data_o    = out_data_q;
  assign out_valid_o   = out_valid_q;
  assign flash_csn_o   = csn_q;
  assign flash_sck_o   = sck;
  assign flash_mosi_o  = tx_q[31];
  assign flash_wpn_o   = 1'b1;
  assign flash_holdn_o = 1'b1;

endmodule

// File: tb/tb_spi_flash_reader.sv
// tb/tb_spi_flash_reader.sv - scoreboard bench with READ flash model, DIV=1 and DIV=3 instances
module tb_spi_flash_reader;

  logic        clk = 1'b0;
  logic        rst, start, out_ready, sel;
  logic [23:0] addr;
  logic [15:0] len;

  logic        busy1, done1, ov1, csn1, sck1, mosi1, wpn1, holdn1;
  logic        busy3, done3, ov3, csn3, sck3, mosi3, wpn3, holdn3;
  logic [7:0]  od1, od3;
  logic        f_miso = 1'b0;

  always #5 clk = !clk;

  spi_flash_reader #(.DIV(1)) u_dut_div1 (
    .clk_i(clk), .rst_i(rst), .start_i(start & !sel), .addr_i(addr), .len_i(len),
    .busy_o(busy1), .done_o(done1), .out_data_o(od1), .out_valid_o(ov1), .out_ready_i(out_ready),
    .flash_csn_o(csn1), .flash_sck_o(sck1), .flash_mosi_o(mosi1), .flash_miso_i(f_miso),
    .flash_wpn_o(wpn1), .flash_holdn_o(holdn1)
  );

  spi_flash_reader #(.DIV(3)) u_dut_div3 (
    .clk_i(clk), .rst_i(rst), .start_i(start & sel), .addr_i(addr), .len_i(len),
    .busy_o(busy3), .done_o(done3), .out_data_o(od3), .out_valid_o(ov3), .out_ready_i(out_ready),
    .flash_csn_o(csn3), .flash_sck_o(sck3), .flash_mosi_o(mosi3), .flash_miso_i(f_miso),
    .flash_wpn_o(wpn3), .flash_holdn_o(holdn3)
  );

  wire       f_csn  = sel ? csn3  : csn1;
  wire       f_sck  = sel ? sck3  : sck1;
  wire       f_mosi = sel ? mosi3 : mosi1;
  wire       busy   = sel ? busy3 : busy1;
  wire       done   = sel ? done3 : done1;
  wire       ovalid = sel ? ov3   : ov1;
  wire [7:0] odata  = sel ? od3   : od1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Flash model: memory byte i reads as i ^ A5
  int          f_bits, f_obit, f_per_min, f_per_max, sck_rises = 0;
  logic [31:0] f_cmdaddr = '0;
  logic [23:0] f_addr;
  logic [7:0]  f_out;
  bit          f_have_rise;
  time         f_last_rise;

  always @(negedge f_csn) begin
    f_bits = 0; f_obit = 0; f_have_rise = 0; f_per_min = 1000000; f_per_max = 0;
  end

  always @(posedge f_sck) begin
    sck_rises++;
    if (!f_csn) begin
      if (f_have_rise) begin
        if (int'($time - f_last_rise) < f_per_min) f_per_min = int'($time - f_last_rise);
        if (int'($time - f_last_rise) > f_per_max) f_per_max = int'($time - f_last_rise);
      end
      f_have_rise = 1; f_last_rise = $time;
      if (f_bits < 32) begin
        f_cmdaddr = {f_cmdaddr[30:0], f_mosi};
        f_bits++;
        if (f_bits == 32) f_addr = f_cmdaddr[23:0];
      end
    end
  end

  always @(negedge f_sck) begin
    if (!f_csn && f_bits >= 32) begin
      if (f_obit == 0) begin f_out = f_addr[7:0] ^ 8'hA5; f_addr++; end
      f_miso = f_out[7 - f_obit];
      f_obit = (f_obit + 1) % 8;
    end
  end

  // Scoreboard and event monitors
  logic [7:0] exp_q[$];
  int done_cnt = 0, csn_low_cnt = 0, hi_run = 0, last_gap = 0;

  always @(negedge clk) begin
    if (!rst && ovalid && out_ready) begin
      if (exp_q.size() > 0) check_eq("byte", {24'b0, odata}, {24'b0, exp_q.pop_front()});
      else check_eq("extra_byte", {24'b0, odata}, 32'h100);
    end
    if (done) done_cnt++;
    if (f_csn) hi_run++;
    else begin
      csn_low_cnt++;
      if (hi_run > 0) last_gap = hi_run;
      hi_run = 0;
    end
  end

  task automatic push_exp(input logic [23:0] a, input int n);
    for (int i = 0; i < n; i++) begin
      logic [23:0] ai;
      ai = a + 24'(i);
      exp_q.push_back(ai[7:0] ^ 8'hA5);
    end
  endtask

  task automatic do_start(input logic [23:0] a, input logic [15:0] n);
    @(posedge clk); #1;
    start = 1'b1; addr = a; len = n;
    push_exp(a, int'(n));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!done && n < budget);
    check_eq({tag, "_done"}, {31'b0, done}, 32'd1);
  endtask

  int r0, d0, c0, r70;

  initial begin
    rst = 1'b1; start = 1'b0; addr = '0; len = '0; out_ready = 1'b1; sel = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_csn",   {31'b0, csn1 & csn3},   32'd1);
    check_eq("rst_sck",   {30'b0, sck1, sck3},    32'd0);
    check_eq("rst_mosi",  {30'b0, mosi1, mosi3},  32'd0);
    check_eq("rst_busy",  {30'b0, busy1, busy3},  32'd0);
    check_eq("rst_done",  {30'b0, done1, done3},  32'd0);
    check_eq("rst_valid", {30'b0, ov1, ov3},      32'd0);
    check_eq("rst_data",  {16'b0, od1, od3},      32'd0);
    check_eq("rst_wp_hold", {28'b0, wpn1, holdn1, wpn3, holdn3}, 32'hF);
    @(posedge clk); #1 rst = 1'b0;

    // DIV=1 basic read
    r0 = sck_rises; d0 = done_cnt;
    do_start(24'h000010, 16'd4);
    wait_done("t1", 400);
    repeat (2) @(negedge clk);
    check_eq("t1_cmdaddr", f_cmdaddr, 32'h03000010);
    check_eq("t1_rises", 32'(sck_rises - r0), 32'd64);
    check_eq("t1_done_once", 32'(done_cnt - d0), 32'd1);
    check_eq("t1_per_min", 32'(f_per_min), 32'd20);
    check_eq("t1_per_max", 32'(f_per_max), 32'd20);
    check_eq("t1_pending", 32'(exp_q.size()), 32'd0);

    // len == 0
    r0 = sck_rises; c0 = csn_low_cnt;
    @(posedge clk); #1;
    start = 1'b1; addr = 24'h000123; len = 16'd0;
    @(negedge clk);
    check_eq("t2_c0_busy", {31'b0, busy}, 32'd0);
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check_eq("t2_c1_busy", {31'b0, busy}, 32'd1);
    check_eq("t2_c1_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    check_eq("t2_c2_done", {31'b0, done}, 32'd1);
    check_eq("t2_c2_busy", {31'b0, busy}, 32'd0);
    repeat (5) @(negedge clk);
    check_eq("t2_no_sck", 32'(sck_rises - r0), 32'd0);
    check_eq("t2_csn_high", 32'(csn_low_cnt - c0), 32'd0);

    // DIV=3 with backpressure after first byte
    sel = 1'b1; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    do_start(24'h0000F0, 16'd3);
    begin
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while (!ovalid && n < 600);
    end
    check_eq("t3_first_valid", {31'b0, ovalid}, 32'd1);
    repeat (70) @(negedge clk);
    r70 = sck_rises;
    repeat (30) @(negedge clk);
    check_eq("t3_sck_frozen", 32'(sck_rises - r70), 32'd0);
    check_eq("t3_sck_low", {31'b0, f_sck}, 32'd0);
    check_eq("t3_csn_low", {31'b0, f_csn}, 32'd0);
    check_eq("t3_held_byte", {24'b0, odata}, 32'h55);
    out_ready = 1'b1;
    wait_done("t3", 600);
    repeat (2) @(negedge clk);
    check_eq("t3_pending", 32'(exp_q.size()), 32'd0);

    // start during busy is ignored
    sel = 1'b0;
    d0 = done_cnt;
    do_start(24'h000020, 16'd2);
    repeat (10) @(posedge clk);
    #1 start = 1'b1; addr = 24'h000099; len = 16'd5;
    @(posedge clk); #1 start = 1'b0;
    wait_done("t4", 400);
    repeat (20) @(negedge clk);
    check_eq("t4_done_once", 32'(done_cnt - d0), 32'd1);
    check_eq("t4_cmdaddr", f_cmdaddr, 32'h03000020);
    check_eq("t4_idle", {30'b0, busy, f_csn}, 32'd1);
    check_eq("t4_pending", 32'(exp_q.size()), 32'd0);

    // reset in the middle of the address phase
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1; addr = 24'h000040; len = 16'd2;
    @(posedge clk); #1 start = 1'b0;
    repeat (30) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_eq("t5_csn", {31'b0, f_csn}, 32'd1);
    check_eq("t5_sck", {31'b0, f_sck}, 32'd0);
    check_eq("t5_busy", {31'b0, busy}, 32'd0);
    check_eq("t5_valid", {31'b0, ovalid}, 32'd0);
    repeat (10) @(negedge clk);
    check_eq("t5_no_done", 32'(done_cnt - d0), 32'd0);
    do_start(24'h000080, 16'd2);
    wait_done("t5", 400);
    repeat (2) @(negedge clk);
    check_eq("t5_cmdaddr", f_cmdaddr, 32'h03000080);
    check_eq("t5_pending", 32'(exp_q.size()), 32'd0);

    // back-to-back at DIV=3: new start issued in the done cycle
    sel = 1'b1;
    repeat (2) @(negedge clk);
    do_start(24'h000100, 16'd1);
    wait_done("t6a", 400);
    start = 1'b1; addr = 24'h0001FF; len = 16'd2;
    push_exp(24'h0001FF, 2);
    @(posedge clk); #1 start = 1'b0;
    wait_done("t6b", 600);
    repeat (2) @(negedge clk);
    check_eq("t6_gap_ok", {31'b0, last_gap >= 4}, 32'd1);
    check_eq("t6_cmdaddr", f_cmdaddr, 32'h030001FF);
    check_eq("t6_per_min", 32'(f_per_min), 32'd60);
    check_eq("t6_per_max", 32'(f_per_max), 32'd60);
    check_eq("t6_pending", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
